vector_response_checker: RTL and testbench
==========================================

# vector_response_checker

Synthesizable expected-response checker downstream of the pattern player. Accepts per-vector expect codes on a valid/ready stream, queues them in a small FIFO to absorb DUT strobe latency, and compares each queued entry against the sampled DUT pins on every strobe. Accumulates a saturating fail count, captures the first failing vector, and reports pass/fail once end-of-pattern is seen and the queue has drained.

## Interface
Parameters:
- NUM_PINS, 23: number of compared pins, matching the pattern pin list.
- VNUM_W, 32: width of the vector number.
- FIFO_DEPTH, 8: expectation queue depth. Must be a power of 2, at least 2.
- CNT_W, 16: width of the fail counter.

Ports:
- clock  in  1  Sole clock. All state updates on the rising edge.
- reset  in  1  Asynchronous, active-low reset.
- start  in  1  One-cycle pulse: clear results and flush the queue, then enter RUN.
- vec_valid  in  1  Expectation entry is valid.
- vec_ready  out  1  Checker accepts the entry this cycle.
- vec_number  in  VNUM_W  Vector number of the entry.
- vec_exp  in  2*NUM_PINS  Per-pin expect code. Pin i is bits [2i+1:2i].
- eop  in  1  End-of-pattern pulse from the player's finished event.
- strobe  in  1  pins_in holds the sampled DUT response for the head entry.
- pins_in  in  NUM_PINS  Sampled DUT outputs.
- busy  out  1  State is RUN or DRAIN.
- done  out  1  State is DONE.
- pass  out  1  Valid only while done is high.
- fail_count  out  CNT_W  Number of failing strobes. Saturates.
- first_fail_vnum  out  VNUM_W  Vector number of the first failing strobe.
- first_fail_mask  out  NUM_PINS  Mismatch mask of the first failing strobe.
- err_underflow  out  1  Sticky. A strobe arrived while the queue was empty.

## Operation
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN on eop.
  - DRAIN -> DONE when the queue is empty.
  - RUN, DRAIN or DONE -> RUN on start, which flushes the queue and clears all results.
  - start and eop in the same cycle: start wins; eop is ignored.
- Push: when vec_valid && vec_ready. vec_ready = (state==RUN) && !full, derived from registered state only. No push while full, even if a pop happens in the same cycle.
- Pop: when strobe && !empty in RUN or DRAIN. Same-cycle push and pop are allowed when not full; occupancy stays unchanged.
- Expect codes: 00 = mask, 01 = expect low, 10 = expect high, 11 = reserved and treated as mask.
- Compare: mismatch[i] = (code==01 && pins_in[i]) || (code==10 && !pins_in[i]). A strobe fails if any mismatch bit is set.
- On a failing strobe:
  - fail_count increments and saturates at all-ones.
  - If fail_count was 0, first_fail_vnum and first_fail_mask are captured. They are never overwritten until start.
- Strobe with an empty queue, or in IDLE or DONE: sets err_underflow in RUN and DRAIN only; no compare. Strobes in IDLE and DONE are ignored.
- pass = (fail_count==0) && !err_underflow.

## Timing
- Reset values:
  - state: IDLE.
  - All outputs 0. vec_ready is 0.
  - Queue empty.
- Latency:
  - A push is visible at the queue head the next cycle.
  - A strobe compares the head combinationally. fail_count, first_fail_* and err_underflow update on the following edge, one cycle after strobe.
- DRAIN -> DONE: the edge after the last pop empties the queue. eop with an empty queue gives RUN -> DRAIN -> DONE in 2 cycles.
- Queue pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished with an extra pointer bit.
- Async reset mid-run discards the queue and all results immediately.

## Configuration
- VECTOR_RESPONSE_CHECKER_PIN_FAIL_EN defined:
  - Adds output pin_fail [NUM_PINS]: a sticky OR of every mismatch mask.
  - Cleared by reset and start.
- Undefined: the port and register are absent. All other behaviour is identical.

## Structure
- Shared package vtw_check_pkg holds:
  - The expect-code constants EXP_MASK, EXP_LOW, EXP_HIGH, EXP_RSVD.
  - The state enum.
  - A function computing the mismatch mask from code and pin vectors.
- One sub-module, vrc_fifo: a parameterized synchronous FIFO with width VNUM_W+2*NUM_PINS and depth FIFO_DEPTH, with full/empty flags.

## Test plan
- Reset, start, push vector 5 with all codes 01, strobe with pins_in=0, eop -> DONE within 2 cycles of the pop, pass=1, fail_count=0.
- Push vectors 10 and 11 with pin 3 coded 10; strobe pins_in=0 twice -> fail_count=2, first_fail_vnum=10, first_fail_mask=1<<3, pass=0.
- Push 8 entries with no strobe -> vec_ready=0 on the 9th attempt; strobe and push in the same cycle while full -> pop only, occupancy 7.
- Strobe right after start with the queue empty -> err_underflow=1, fail_count=0; after eop -> pass=0.
- CNT_W=2, 5 failing strobes -> fail_count=3 held; start -> all results cleared, state RUN.
- With the macro: failures on pins 1 then 4 -> pin_fail=0x12; without the macro, the build has no pin_fail port.

Source files
------------

// File: rtl/vtw_check_pkg.sv
// Shared definitions for the vector response checker: expect codes, FSM states and
// the per-pin mismatch function.
package vtw_check_pkg;

  localparam logic [1:0] EXP_MASK = 2'b00;
  localparam logic [1:0] EXP_LOW  = 2'b01;
  localparam logic [1:0] EXP_HIGH = 2'b10;
  localparam logic [1:0] EXP_RSVD = 2'b11;

  // Widest pin list the mismatch function handles; callers zero-pad (code 00 = mask).
  localparam int unsigned MAX_PINS = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic logic [MAX_PINS-1:0] mismatch_mask(input logic [2*MAX_PINS-1:0] codes,
                                                        input logic [MAX_PINS-1:0]   pins);
    logic [MAX_PINS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PINS; i++) begin
      case (codes[2*i +: 2])
        EXP_LOW:  m[i] = pins[i];
        EXP_HIGH: m[i] = !pins[i];
        default:  m[i] = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/vrc_fifo.sv
// Synchronous FIFO holding queued expectation entries; extra pointer bit separates
// full from empty. DEPTH must be a power of 2, at least 2.
module vrc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata   = mem[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vector_response_checker.sv
// Expected-response checker: queues per-vector expect codes and compares them against
// sampled DUT pins on each strobe. Optional sticky per-pin fail vector under
// VECTOR_RESPONSE_CHECKER_PIN_FAIL_EN.
module vector_response_checker
  import vtw_check_pkg::*;
#(
  parameter int unsigned NUM_PINS   = 23,
  parameter int unsigned VNUM_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  vec_valid,
  output logic                  vec_ready,
  input  logic [VNUM_W-1:0]     vec_number,
  input  logic [2*NUM_PINS-1:0] vec_exp,
  input  logic                  eop,
  input  logic                  strobe,
  input  logic [NUM_PINS-1:0]   pins_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      fail_count,
  output logic [VNUM_W-1:0]     first_fail_vnum,
  output logic [NUM_PINS-1:0]   first_fail_mask,
  output logic                  err_underflow
`ifdef VECTOR_RESPONSE_CHECKER_PIN_FAIL_EN
  ,
  output logic [NUM_PINS-1:0]   pin_fail
`endif
);

  localparam int unsigned EW = VNUM_W + 2*NUM_PINS;

  state_e                state_q, state_d;
  logic                  full, empty;
  logic [EW-1:0]         head;
  logic [VNUM_W-1:0]     head_vnum;
  logic [2*NUM_PINS-1:0] head_exp;
  logic                  push, pop, active_strobe, underflow_evt, fail_evt;
  logic [NUM_PINS-1:0]   mismatch;

  logic [2*MAX_PINS-1:0] codes_ext;
  logic [MAX_PINS-1:0]   pins_ext;
  logic [MAX_PINS-1:0]   mm_ext;
  logic                  unused_mm;

  logic [CNT_W-1:0]      fail_count_q;
  logic [VNUM_W-1:0]     first_vnum_q;
  logic [NUM_PINS-1:0]   first_mask_q;
  logic                  underflow_q;

  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign vec_ready = (state_q == StRun) && !full;
  assign push      = vec_valid && vec_ready;

  assign active_strobe = strobe && busy;
  assign pop           = active_strobe && !empty;
  assign underflow_evt = active_strobe && empty;

  vrc_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(start),
    .push (push),
    .pop  (pop),
    .wdata({vec_number, vec_exp}),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  assign head_vnum = head[EW-1 -: VNUM_W];
  assign head_exp  = head[2*NUM_PINS-1:0];

  always_comb begin
    codes_ext = '0;
    codes_ext[2*NUM_PINS-1:0] = head_exp;
    pins_ext = '0;
    pins_ext[NUM_PINS-1:0] = pins_in;
  end

  assign mm_ext    = mismatch_mask(codes_ext, pins_ext);
  assign mismatch  = mm_ext[NUM_PINS-1:0];
  assign unused_mm = ^mm_ext;
  assign fail_evt  = pop && (|mismatch);

  // start overrides every transition, including a coincident eop.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StRun;
    end else begin
      case (state_q)
        StRun:   if (eop) state_d = StDrain;
        StDrain: if (empty) state_d = StDone;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      fail_count_q <= '0;
      first_vnum_q <= '0;
      first_mask_q <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        fail_count_q <= '0;
        first_vnum_q <= '0;
        first_mask_q <= '0;
        underflow_q  <= 1'b0;
      end else begin
        if (fail_evt) begin
          if (fail_count_q != {CNT_W{1'b1}}) fail_count_q <= fail_count_q + CNT_W'(1);
          if (fail_count_q == '0) begin
            first_vnum_q <= head_vnum;
            first_mask_q <= mismatch;
          end
        end
        if (underflow_evt) underflow_q <= 1'b1;
      end
    end
  end

`ifdef VECTOR_RESPONSE_CHECKER_PIN_FAIL_EN
  logic [NUM_PINS-1:0] pin_fail_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pin_fail_q <= '0;
    end else if (start) begin
      pin_fail_q <= '0;
    end else if (pop) begin
      pin_fail_q <= pin_fail_q | mismatch;
    end
  end

  assign pin_fail = pin_fail_q;
`endif

  assign fail_count      = fail_count_q;
  assign first_fail_vnum = first_vnum_q;
  assign first_fail_mask = first_mask_q;
  assign err_underflow   = underflow_q;
  // pass is only meaningful in DONE, so it is held low elsewhere.
  assign pass            = done && (fail_count_q == '0) && !underflow_q;

endmodule

// File: tb/tb_vector_response_checker.sv
// Scoreboard bench for vector_response_checker; a CNT_W=2 twin shares all inputs to
// exercise counter saturation.
module tb_vector_response_checker;

  localparam int NP = 23;
  localparam int VW = 32;
  localparam int CW = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            vec_valid = 1'b0;
  logic [VW-1:0]   vec_number = '0;
  logic [2*NP-1:0] vec_exp = '0;
  logic            eop = 1'b0;
  logic            strobe = 1'b0;
  logic [NP-1:0]   pins_in = '0;

  logic            vec_ready, busy, done, pass, err_underflow;
  logic [CW-1:0]   fail_count;
  logic [VW-1:0]   first_fail_vnum;
  logic [NP-1:0]   first_fail_mask;

  logic            unused2_ready, unused2_busy, unused2_done, unused2_pass, unused2_uf;
  logic [1:0]      fail_count2;
  logic [VW-1:0]   unused2_vnum;
  logic [NP-1:0]   unused2_mask;
`ifdef VECTOR_RESPONSE_CHECKER_PIN_FAIL_EN
  logic [NP-1:0]   pin_fail;
  logic [NP-1:0]   unused2_pin_fail;
`endif

  always #5 clock = ~clock;

  vector_response_checker #(
    .NUM_PINS(NP), .VNUM_W(VW), .FIFO_DEPTH(8), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_number(vec_number), .vec_exp(vec_exp), .eop(eop),
    .strobe(strobe), .pins_in(pins_in), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_vnum(first_fail_vnum),
    .first_fail_mask(first_fail_mask), .err_underflow(err_underflow)
`ifdef VECTOR_RESPONSE_CHECKER_PIN_FAIL_EN
    , .pin_fail(pin_fail)
`endif
  );

  vector_response_checker #(
    .NUM_PINS(NP), .VNUM_W(VW), .FIFO_DEPTH(8), .CNT_W(2)
  ) dut2 (
    .clock(clock), .reset(reset), .start(start), .vec_valid(vec_valid),
    .vec_ready(unused2_ready), .vec_number(vec_number), .vec_exp(vec_exp), .eop(eop),
    .strobe(strobe), .pins_in(pins_in), .busy(unused2_busy), .done(unused2_done),
    .pass(unused2_pass), .fail_count(fail_count2), .first_fail_vnum(unused2_vnum),
    .first_fail_mask(unused2_mask), .err_underflow(unused2_uf)
`ifdef VECTOR_RESPONSE_CHECKER_PIN_FAIL_EN
    , .pin_fail(unused2_pin_fail)
`endif
  );

  typedef struct {
    logic [CW-1:0] fc;
    logic [1:0]    fc2;
    logic [VW-1:0] vnum;
    logic [NP-1:0] mask;
    logic          uf;
    logic          ps;
    logic [NP-1:0] pf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one scoreboard entry is consumed each time DONE is entered.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("fail_count", 64'(fail_count), 64'(e.fc));
          check("fail_count_cnt2", 64'(fail_count2), 64'(e.fc2));
          check("first_fail_vnum", 64'(first_fail_vnum), 64'(e.vnum));
          check("first_fail_mask", 64'(first_fail_mask), 64'(e.mask));
          check("err_underflow", 64'(err_underflow), 64'(e.uf));
          check("pass", 64'(pass), 64'(e.ps));
`ifdef VECTOR_RESPONSE_CHECKER_PIN_FAIL_EN
          check("pin_fail", 64'(pin_fail), 64'(e.pf));
`endif
        end
      end
      done_prev = done;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_vec(input logic [VW-1:0] vn, input logic [2*NP-1:0] ex);
    vec_valid  = 1'b1;
    vec_number = vn;
    vec_exp    = ex;
    check("vec_ready_on_push", 64'(vec_ready), 64'(1));
    tick();
    vec_valid = 1'b0;
  endtask

  task automatic strobe_pins(input logic [NP-1:0] p);
    strobe  = 1'b1;
    pins_in = p;
    tick();
    strobe = 1'b0;
  endtask

  task automatic expect_result(input logic [CW-1:0] fc, input logic [1:0] fc2,
                               input logic [VW-1:0] vn, input logic [NP-1:0] mk,
                               input logic uf, input logic ps, input logic [NP-1:0] pf);
    exp_t e;
    e.fc = fc; e.fc2 = fc2; e.vnum = vn; e.mask = mk; e.uf = uf; e.ps = ps; e.pf = pf;
    sb.push_back(e);
  endtask

  // eop then a bounded wait for DONE; ticks counted after the eop edge.
  task automatic finish_and_wait(input int limit);
    int n;
    eop = 1'b1;
    tick();
    eop = 1'b0;
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    check("done_within_bound", 64'(done), 64'(1));
    if (!done) sb.delete();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [2*NP-1:0] one_pin(input int pin, input logic [1:0] code);
    logic [2*NP-1:0] r;
    r = '0;
    r[2*pin +: 2] = code;
    return r;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pass", 64'(pass), 64'(0));
    check("rst_vec_ready", 64'(vec_ready), 64'(0));
    check("rst_fail_count", 64'(fail_count), 64'(0));
    check("rst_underflow", 64'(err_underflow), 64'(0));
    reset = 1'b1;
    tick();
    check("idle_vec_ready", 64'(vec_ready), 64'(0));

    // Passing vectors, including reserved code and expect-high matching
    do_start();
    check("run_busy", 64'(busy), 64'(1));
    push_vec(32'd5, {NP{2'b01}});
    push_vec(32'd6, {NP{2'b11}});
    push_vec(32'd7, one_pin(2, 2'b10));
    strobe_pins('0);
    strobe_pins(23'h5A5A5A);
    strobe_pins(23'h000004);
    expect_result(16'd0, 2'd0, 32'd0, '0, 1'b0, 1'b1, '0);
    finish_and_wait(2);

    // Two failures on pin 3; first capture must stick to vector 10
    do_start();
    push_vec(32'd10, one_pin(3, 2'b10));
    push_vec(32'd11, one_pin(3, 2'b10));
    strobe_pins('0);
    strobe_pins('0);
    expect_result(16'd2, 2'd2, 32'd10, 23'h8, 1'b0, 1'b0, 23'h8);
    finish_and_wait(2);

    // Fill the queue; a strobe while full pops without pushing
    do_start();
    for (int i = 0; i < 8; i++) push_vec(32'(20 + i), '0);
    vec_valid  = 1'b1;
    vec_number = 32'd28;
    check("full_vec_ready", 64'(vec_ready), 64'(0));
    strobe_pins('0);
    vec_valid = 1'b0;
    check("after_pop_vec_ready", 64'(vec_ready), 64'(1));
    push_vec(32'd99, '0);
    check("refull_vec_ready", 64'(vec_ready), 64'(0));
    for (int i = 0; i < 8; i++) strobe_pins(23'(i * 7));
    expect_result(16'd0, 2'd0, 32'd0, '0, 1'b0, 1'b1, '0);
    finish_and_wait(2);

    // Strobe with an empty queue
    do_start();
    strobe_pins('0);
    check("underflow_set", 64'(err_underflow), 64'(1));
    check("underflow_no_fail", 64'(fail_count), 64'(0));
    expect_result(16'd0, 2'd0, 32'd0, '0, 1'b1, 1'b0, '0);
    finish_and_wait(2);

    // Five failures: 2-bit twin saturates at 3; same-cycle push and pop
    do_start();
    push_vec(32'd40, one_pin(0, 2'b01));
    for (int i = 0; i < 4; i++) begin
      vec_valid  = 1'b1;
      vec_number = 32'(41 + i);
      vec_exp    = one_pin(0, 2'b01);
      check("pushpop_vec_ready", 64'(vec_ready), 64'(1));
      strobe_pins(23'h1);
      vec_valid = 1'b0;
    end
    strobe_pins(23'h1);
    check("fail_count_5", 64'(fail_count), 64'(5));
    check("fail_count2_sat", 64'(fail_count2), 64'(3));
    expect_result(16'd5, 2'd3, 32'd40, 23'h1, 1'b0, 1'b0, 23'h1);
    finish_and_wait(2);
    do_start();
    check("clr_fail_count", 64'(fail_count), 64'(0));
    check("clr_fail_count2", 64'(fail_count2), 64'(0));
    check("clr_first_vnum", 64'(first_fail_vnum), 64'(0));
    check("clr_first_mask", 64'(first_fail_mask), 64'(0));
    check("clr_busy", 64'(busy), 64'(1));
    check("clr_done", 64'(done), 64'(0));

    // Failures on pin 1 then pin 4
    push_vec(32'd50, one_pin(1, 2'b01));
    push_vec(32'd51, one_pin(4, 2'b10));
    strobe_pins(23'h2);
    strobe_pins(23'h0);
    expect_result(16'd2, 2'd2, 32'd50, 23'h2, 1'b0, 1'b0, 23'h12);
    finish_and_wait(2);

    // Async reset mid-run discards results
    do_start();
    push_vec(32'd60, one_pin(0, 2'b10));
    strobe_pins('0);
    check("pre_reset_fail_count", 64'(fail_count), 64'(1));
    #2 reset = 1'b0;
    #1;
    check("mid_reset_busy", 64'(busy), 64'(0));
    check("mid_reset_fail_count", 64'(fail_count), 64'(0));
    check("mid_reset_vec_ready", 64'(vec_ready), 64'(0));
    #1 reset = 1'b1;
    tick();

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
